// File: rtl/eth_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_arb_pkg
//  Description : Shared types and constants for the 2:1 frame arbiter that
//                fronts a shared 64-bit Ethernet FCS checker.
//                  - state_e : arbiter FSM states
//                  - PORT_W  : width of a source-port identifier / tag
//  Revision    : 1.0  initial release
// ============================================================================
package eth_arb_pkg;

   localparam int PORT_W = 1;

   typedef enum logic [0:0] {
      STATE_IDLE   = 1'b0,
      STATE_ACTIVE = 1'b1
   } state_e;

endpackage
`default_nettype wire

// File: rtl/tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tag_fifo
//  Description : Synchronous FIFO holding the source-port tag of every frame
//                currently inside the shared checker. Pointers carry one
//                extra wrap bit so full and empty are told apart without a
//                separate counter.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                push_i          write push_data_i (ignored when full
//                                unless a pop happens in the same cycle)
//                push_data_i     tag to store
//                pop_i           discard head (ignored when empty)
//                head_o          oldest tag
//                full_o          registered: DEPTH entries held
//                empty_o         no entries held
//  Revision    : 1.0  initial release
// ============================================================================
module tag_fifo
   import eth_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [PORT_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [PORT_W-1:0] head_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_q, wr_d;
   logic [AW:0]       rd_q, rd_d;
   logic              full_q, full_d;
   logic [PORT_W-1:0] mem_q [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = full_q;
   assign head_o  = mem_q[rd_q[AW-1:0]];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_q || do_pop);

   always_comb begin
      wr_d   = wr_q + (AW+1)'(do_push);
      rd_d   = rd_q + (AW+1)'(do_pop);
      full_d = ((wr_d - rd_d) == (AW+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         full_q <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         full_q <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axis_eth_fcs_check_arb_64.sv
`default_nettype none
// ============================================================================
//  Module      : axis_eth_fcs_check_arb_64
//  Description : Frame-granular round-robin arbiter sharing one 64-bit FCS
//                checker between two MAC RX streams. Whole frames from the
//                granted port are wired into the checker; every checker
//                output frame is tagged with the port it came from, and
//                per-port delivered / bad frame counters are kept.
//  Ports       : clk, rst                  clock, sync active-high reset
//                s0_axis_*, s1_axis_*      RX streams (tready is output)
//                ck_in_axis_*              to checker input
//                ck_out_axis_*             from checker output
//                m_axis_*, m_axis_tid      downstream stream + source port
//                stat_clear                pulse, zeroes all counters
//                stat_frames0/1            delivered frames per port
//                stat_bad0/1               delivered frames with tuser=1
//                tag_full                  tag FIFO full, grant withheld
//  Revision    : 1.0  initial release
// ============================================================================
module axis_eth_fcs_check_arb_64
   import eth_arb_pkg::*;
#(
   parameter int TAG_FIFO_DEPTH = 4,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic [63:0]          s0_axis_tdata,
   input  logic [7:0]           s0_axis_tkeep,
   input  logic                 s0_axis_tvalid,
   output logic                 s0_axis_tready,
   input  logic                 s0_axis_tlast,
   input  logic                 s0_axis_tuser,

   input  logic [63:0]          s1_axis_tdata,
   input  logic [7:0]           s1_axis_tkeep,
   input  logic                 s1_axis_tvalid,
   output logic                 s1_axis_tready,
   input  logic                 s1_axis_tlast,
   input  logic                 s1_axis_tuser,

   output logic [63:0]          ck_in_axis_tdata,
   output logic [7:0]           ck_in_axis_tkeep,
   output logic                 ck_in_axis_tvalid,
   input  logic                 ck_in_axis_tready,
   output logic                 ck_in_axis_tlast,
   output logic                 ck_in_axis_tuser,

   input  logic [63:0]          ck_out_axis_tdata,
   input  logic [7:0]           ck_out_axis_tkeep,
   input  logic                 ck_out_axis_tvalid,
   output logic                 ck_out_axis_tready,
   input  logic                 ck_out_axis_tlast,
   input  logic                 ck_out_axis_tuser,

   output logic [63:0]          m_axis_tdata,
   output logic [7:0]           m_axis_tkeep,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   output logic                 m_axis_tid,

   input  logic                 stat_clear,
   output logic [CNT_WIDTH-1:0] stat_frames0,
   output logic [CNT_WIDTH-1:0] stat_frames1,
   output logic [CNT_WIDTH-1:0] stat_bad0,
   output logic [CNT_WIDTH-1:0] stat_bad1,
   output logic                 tag_full
);

   state_e              state_q, state_d;
   logic [PORT_W-1:0]   grant_q, grant_d;
   logic [PORT_W-1:0]   last_q, last_d;
   logic [PORT_W-1:0]   winner;

   logic                tag_push;
   logic                tag_pop;
   logic [PORT_W-1:0]   tag_head;
   logic                tag_full_w;
   logic                tag_empty;
   logic                can_grant;

   logic [CNT_WIDTH-1:0] frames0_q, frames0_d;
   logic [CNT_WIDTH-1:0] frames1_q, frames1_d;
   logic [CNT_WIDTH-1:0] bad0_q,    bad0_d;
   logic [CNT_WIDTH-1:0] bad1_q,    bad1_d;

   // ------------------------------------------------------------------------
   // Output path: zero-latency pass-through, tagged from the FIFO head.
   // ------------------------------------------------------------------------
   assign m_axis_tdata       = ck_out_axis_tdata;
   assign m_axis_tkeep       = ck_out_axis_tkeep;
   assign m_axis_tvalid      = ck_out_axis_tvalid;
   assign m_axis_tlast       = ck_out_axis_tlast;
   assign m_axis_tuser       = ck_out_axis_tuser;
   assign ck_out_axis_tready = m_axis_tready;

   // An output frame with no tag behind it is a protocol violation; report
   // port 0 and leave the FIFO alone.
   assign m_axis_tid = tag_empty ? 1'b0 : tag_head[0];
   assign tag_pop    = ck_out_axis_tvalid && m_axis_tready && ck_out_axis_tlast
                       && !tag_empty;

   // A pop in this cycle frees a slot, so a full FIFO need not delay a grant.
   assign can_grant = !tag_full_w || tag_pop;
   assign tag_full  = tag_full_w;

   // With both ports requesting, the one not served last wins; otherwise the
   // single requester wins (s1 valid alone selects port 1).
   assign winner = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_q
                                                      : PORT_W'(s1_axis_tvalid);

   // ------------------------------------------------------------------------
   // Input mux: only the granted port sees the checker's tready.
   // ------------------------------------------------------------------------
   always_comb begin
      ck_in_axis_tdata  = '0;
      ck_in_axis_tkeep  = '0;
      ck_in_axis_tvalid = 1'b0;
      ck_in_axis_tlast  = 1'b0;
      ck_in_axis_tuser  = 1'b0;
      s0_axis_tready    = 1'b0;
      s1_axis_tready    = 1'b0;
      if (state_q == STATE_ACTIVE) begin
         if (grant_q == '0) begin
            ck_in_axis_tdata  = s0_axis_tdata;
            ck_in_axis_tkeep  = s0_axis_tkeep;
            ck_in_axis_tvalid = s0_axis_tvalid;
            ck_in_axis_tlast  = s0_axis_tlast;
            ck_in_axis_tuser  = s0_axis_tuser;
            s0_axis_tready    = ck_in_axis_tready;
         end else begin
            ck_in_axis_tdata  = s1_axis_tdata;
            ck_in_axis_tkeep  = s1_axis_tkeep;
            ck_in_axis_tvalid = s1_axis_tvalid;
            ck_in_axis_tlast  = s1_axis_tlast;
            ck_in_axis_tuser  = s1_axis_tuser;
            s1_axis_tready    = ck_in_axis_tready;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Arbiter FSM
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      tag_push = 1'b0;
      case (state_q)
         STATE_IDLE: begin
            if ((s0_axis_tvalid || s1_axis_tvalid) && can_grant) begin
               grant_d = winner;
               last_d  = winner;
               state_d = STATE_ACTIVE;
            end
         end
         STATE_ACTIVE: begin
            if (ck_in_axis_tvalid && ck_in_axis_tready && ck_in_axis_tlast) begin
               tag_push = 1'b1;
               state_d  = STATE_IDLE;
            end
         end
         default: begin
            state_d = STATE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= STATE_IDLE;
         grant_q <= '0;
         last_q  <= '1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   tag_fifo #(
      .DEPTH (TAG_FIFO_DEPTH)
   ) u_tag_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (tag_push),
      .push_data_i (grant_q),
      .pop_i       (tag_pop),
      .head_o      (tag_head),
      .full_o      (tag_full_w),
      .empty_o     (tag_empty)
   );

   // ------------------------------------------------------------------------
   // Statistics: clear wins over a same-cycle increment, which is dropped.
   // ------------------------------------------------------------------------
   always_comb begin
      frames0_d = frames0_q;
      frames1_d = frames1_q;
      bad0_d    = bad0_q;
      bad1_d    = bad1_q;
      if (stat_clear) begin
         frames0_d = '0;
         frames1_d = '0;
         bad0_d    = '0;
         bad1_d    = '0;
      end else if (tag_pop) begin
         if (tag_head == '0) begin
            frames0_d = frames0_q + CNT_WIDTH'(1);
            if (ck_out_axis_tuser) begin
               bad0_d = bad0_q + CNT_WIDTH'(1);
            end
         end else begin
            frames1_d = frames1_q + CNT_WIDTH'(1);
            if (ck_out_axis_tuser) begin
               bad1_d = bad1_q + CNT_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frames0_q <= '0;
         frames1_q <= '0;
         bad0_q    <= '0;
         bad1_q    <= '0;
      end else begin
         frames0_q <= frames0_d;
         frames1_q <= frames1_d;
         bad0_q    <= bad0_d;
         bad1_q    <= bad1_d;
      end
   end

   assign stat_frames0 = frames0_q;
   assign stat_frames1 = frames1_q;
   assign stat_bad0    = bad0_q;
   assign stat_bad1    = bad1_q;

endmodule
`default_nettype wire

// File: doc/axis_eth_fcs_check_arb_64.md
# axis_eth_fcs_check_arb_64

Frame-granular 2:1 round-robin arbiter that shares one 64-bit `axis_eth_fcs_check_64` instance between two MAC RX streams. It forwards whole frames from the granted port into the checker and tags each checker output frame with its source port. It also keeps per-port frame and bad-frame statistics. It sits between the two RX MAC/PHY adapters and the shared FCS checker, whose output it forwards downstream.

## Interface
Parameters:
- TAG_FIFO_DEPTH, 4: maximum frames in flight inside the checker. Power of two, ≥2.
- CNT_WIDTH, 32: width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s0_axis_{tdata,tkeep,tvalid,tready,tlast,tuser}  in/out  64/8/1/1/1/1  RX port 0. tready is an output.
- s1_axis_{tdata,tkeep,tvalid,tready,tlast,tuser}  in/out  64/8/1/1/1/1  RX port 1. tready is an output.
- ck_in_axis_{tdata,tkeep,tvalid,tready,tlast,tuser}  out/in  64/8/1/1/1/1  to checker s_axis. tready is an input.
- ck_out_axis_{tdata,tkeep,tvalid,tready,tlast,tuser}  in/out  64/8/1/1/1/1  from checker m_axis. tready is an output.
- m_axis_{tdata,tkeep,tvalid,tready,tlast,tuser}  out/in  64/8/1/1/1/1  downstream. tready is an input.
- m_axis_tid  out  1  source port of the current output frame
- stat_clear  in  1  pulse; zeroes all counters
- stat_frames0, stat_frames1  out  CNT_WIDTH  frames delivered per port
- stat_bad0, stat_bad1  out  CNT_WIDTH  delivered frames with tuser=1, per port
- tag_full  out  1  tag FIFO full (grant blocked)

## Operation
- FSM states:
  - IDLE
  - ACTIVE: holds the registered grant_port.
- In IDLE:
  - Candidates are ports with tvalid=1.
  - Priority goes to the port not equal to last_port. last_port resets to 1, so port 0 wins first.
  - A grant requires tag FIFO not full.
  - On grant: grant_port ← winner, last_port ← winner, go to ACTIVE. No data transfers in IDLE; both s*_tready=0.
- In ACTIVE:
  - The granted port is combinationally wired to ck_in_axis (data, keep, valid, last, user).
  - Granted port tready = ck_in_axis_tready. The other port's tready = 0.
  - On a granted-port handshake with tlast=1: push grant_port into the tag FIFO and return to IDLE.
- Output path:
  - m_axis_* = ck_out_axis_*, combinational pass-through; ck_out_axis_tready = m_axis_tready.
  - m_axis_tid = tag FIFO head.
  - On an m_axis handshake with tlast=1: pop the tag, increment stat_frames[head], and increment stat_bad[head] if tuser=1.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- Counters wrap modulo 2^CNT_WIDTH.
- stat_clear has priority over a same-cycle increment. The counters read 0 next cycle; that cycle's event is lost.
- Frames are never interleaved or truncated. A port stalling mid-frame holds the grant indefinitely.
- Tag FIFO empty while ck_out_axis_tvalid=1 is a protocol violation. In that case m_axis_tid is 0 and nothing pops. The bench flags it.

## Timing
- Reset values:
  - state IDLE; last_port 1; tag FIFO empty.
  - All counters 0; tag_full 0.
  - s0/s1 tready 0; ck_in tvalid 0.
  - m_axis_tvalid follows ck_out (0 after checker reset).
- Reset mid-frame: the frame is abandoned and tags are flushed. The checker shares rst.
- Grant latency: 1 cycle from first tvalid seen in IDLE to the first data beat.
- Frame gap: 1 idle cycle between consecutive frames. Peak throughput is N/(N+1) for N-beat frames.
- The data path adds zero latency; the checker's own latency is excluded.
- Counters update the cycle after the output tlast handshake.
- tag_full is registered from the occupancy count. With the FIFO full, grant is withheld until a pop. A pop in IDLE permits grant the same cycle.

## Structure
- Shared package eth_arb_pkg holds:
  - state enum (STATE_IDLE, STATE_ACTIVE)
  - port-ID width localparam PORT_W=1
- Sub-module: tag_fifo, a synchronous 1-bit-wide FIFO of TAG_FIFO_DEPTH entries with push, pop, head, full and empty. Pointers are log2(depth)+1 bits wide.
- The checker is instantiated by the parent, not inside this block.

## Test plan
- Reset, then port 0 sends a 3-beat frame with a good FCS:
  - ck_in sees 3 beats starting 1 cycle after tvalid.
  - Output has tid=0 and tuser=0.
  - Counters: stat_frames0=1, stat_bad0=0.
- Both ports valid continuously with 2-beat frames (4 frames total):
  - Grant order is 0,1,0,1.
  - No beats are interleaved.
  - Output tids come out 0,1,0,1.
- Port 1 frame with a corrupted FCS byte:
  - Output tuser=1 and tid=1.
  - Counters: stat_bad1=1, stat_frames1=1.
- m_axis_tready held 0 while 5 single-beat frames are offered (TAG_FIFO_DEPTH=4):
  - tag_full asserts once enough frames are in flight; no further grant.
  - Release tready: all 5 frames are delivered in order with correct tids.
- stat_clear asserted on the same cycle as an output tlast:
  - All counters read 0 next cycle.
  - The next frame yields a count of 1.
- rst pulsed mid-frame on port 0:
  - All outputs return to reset values.
  - The next frame is granted to port 0 with correct tid.
